// File: rtl/ps2_init_sequencer.sv
// PS/2 keyboard init sequencer.
// Walks a parameterised table of {cmd, cmd_data} entries. Each entry is handed
// to the PS/2 controller with a cmd_exec/busy/cmd_complete handshake, and the
// sequencer then checks the keyboard's response byte.
//   0xFA (or 0xAA after a 0xFF reset command) -> next entry
//   0xFE or timeout                           -> resend, up to MAX_RETRIES times
//   any other byte                            -> abort with error
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             pulse; restarts the sequence from entry 0
//   busy              controller busy
//   cmd_complete      pulse; cmd_result is valid in that cycle
//   cmd_result[7:0]   keyboard response byte
//   cmd, cmd_data     command and argument presented to the controller
//   cmd_exec          command request level
//   done / error      sticky completion / abort flags
//   err_index[3:0]    table entry that was being processed at the abort
//   err_code[1:0]     0 none, 1 timeout, 2 retries exhausted, 3 bad response
//   active            high while a sequence is in progress
//
// state      | meaning
// IDLE       | out of reset; starts automatically on the next cycle
// WAIT_READY | wait for the controller to be idle (busy low)
// ISSUE      | load cmd/cmd_data for the current entry, raise cmd_exec
// WAIT_BUSY  | hold cmd_exec until the controller accepts it (busy high)
// WAIT_CMPL  | wait for cmd_complete and capture the response byte
// CHECK      | evaluate the response byte
// DONE       | every entry ACKed
// ERROR      | sequence aborted; err_code/err_index describe why
module ps2_init_sequencer #(
  parameter int                     NUM_CMDS       = 4,
  parameter logic [NUM_CMDS*16-1:0] INIT_TABLE     = {8'hFF, 8'h00, 8'hF3, 8'h20,
                                                      8'hED, 8'h00, 8'hF4, 8'h00},
  parameter int                     MAX_RETRIES    = 2,
  parameter int                     TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       busy,
  input  logic       cmd_complete,
  input  logic [7:0] cmd_result,
  output logic [7:0] cmd,
  output logic [7:0] cmd_data,
  output logic       cmd_exec,
  output logic       done,
  output logic       error,
  output logic [3:0] err_index,
  output logic [1:0] err_code,
  output logic       active
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    LAST_IDX = 4'(NUM_CMDS - 1);

  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_RETRY   = 2'd2;
  localparam logic [1:0] ERR_RESP    = 2'd3;

  typedef enum logic [2:0] {
    IDLE, WAIT_READY, ISSUE, WAIT_BUSY, WAIT_CMPL, CHECK, DONE, ERROR
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    idx, idx_nxt;
  logic [2:0]    retry_cnt, retry_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt, tcnt_inc;
  logic [7:0]    result_q, result_nxt;
  logic [7:0]    cmd_nxt, cmd_data_nxt;
  logic          cmd_exec_nxt, done_nxt, error_nxt;
  logic [3:0]    err_index_nxt;
  logic [1:0]    err_code_nxt;
  logic [15:0]   entry;
  logic          timeout, ack, fail_attempt;
  logic [1:0]    fail_code;

  // Entry 0 sits in the most significant 16 bits of INIT_TABLE. Slots beyond
  // NUM_CMDS read as zero so the 4-bit index never selects outside the array.
  logic [15:0] table_mem [16];
  for (genvar g = 0; g < 16; g++) begin : g_table
    if (g < NUM_CMDS) begin : g_used
      assign table_mem[g] = INIT_TABLE[16*(NUM_CMDS-1-g) +: 16];
    end else begin : g_unused
      assign table_mem[g] = 16'h0000;
    end
  end

  assign active = (state != IDLE) && (state != DONE) && (state != ERROR);

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    retry_nxt     = retry_cnt;
    tcnt_nxt      = tcnt;
    result_nxt    = result_q;
    cmd_nxt       = cmd;
    cmd_data_nxt  = cmd_data;
    cmd_exec_nxt  = cmd_exec;
    done_nxt      = done;
    error_nxt     = error;
    err_index_nxt = err_index;
    err_code_nxt  = err_code;
    fail_attempt  = 1'b0;
    fail_code     = ERR_RETRY;
    entry         = table_mem[idx];
    // The counter saturates at TIMEOUT_CYCLES instead of wrapping.
    tcnt_inc      = (tcnt == T_MAX) ? tcnt : tcnt + TW'(1);
    // T_LAST marks the TIMEOUT_CYCLES-th cycle that cmd_exec has been up.
    timeout       = (tcnt == T_LAST);
    // cmd still holds the command of the entry being checked.
    ack           = (result_q == 8'hFA) || ((result_q == 8'hAA) && (cmd == 8'hFF));

    case (state)
      IDLE:       state_nxt = WAIT_READY;
      WAIT_READY: if (!busy) state_nxt = ISSUE;
      ISSUE: begin
        cmd_nxt      = entry[15:8];
        cmd_data_nxt = entry[7:0];
        cmd_exec_nxt = 1'b1;
        tcnt_nxt     = '0;
        state_nxt    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        tcnt_nxt = tcnt_inc;
        if (timeout) begin
          fail_attempt = 1'b1;
          fail_code    = ERR_TIMEOUT;
        end else if (busy) begin
          cmd_exec_nxt = 1'b0;
          state_nxt    = WAIT_CMPL;
        end
      end
      WAIT_CMPL: begin
        tcnt_nxt = tcnt_inc;
        // A completion that lands on the expiry cycle still counts.
        if (cmd_complete) begin
          result_nxt = cmd_result;
          state_nxt  = CHECK;
        end else if (timeout) begin
          fail_attempt = 1'b1;
          fail_code    = ERR_TIMEOUT;
        end
      end
      CHECK: begin
        if (ack) begin
          retry_nxt = '0;
          if (idx == LAST_IDX) begin
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + 4'd1;
            state_nxt = ISSUE;
          end
        end else if (result_q == 8'hFE) begin
          fail_attempt = 1'b1;
        end else begin
          error_nxt     = 1'b1;
          err_code_nxt  = ERR_RESP;
          err_index_nxt = idx;
          state_nxt     = ERROR;
        end
      end
      DONE, ERROR: ;
      default: state_nxt = IDLE;
    endcase

    // Resend (0xFE) and timeout share one retry budget per entry.
    if (fail_attempt) begin
      cmd_exec_nxt = 1'b0;
      if (int'(retry_cnt) < MAX_RETRIES) begin
        retry_nxt = retry_cnt + 3'd1;
        state_nxt = WAIT_READY;
      end else begin
        error_nxt     = 1'b1;
        err_code_nxt  = fail_code;
        err_index_nxt = idx;
        state_nxt     = ERROR;
      end
    end

    if (start) begin
      state_nxt     = WAIT_READY;
      idx_nxt       = '0;
      retry_nxt     = '0;
      tcnt_nxt      = '0;
      cmd_exec_nxt  = 1'b0;
      done_nxt      = 1'b0;
      error_nxt     = 1'b0;
      err_index_nxt = '0;
      err_code_nxt  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      retry_cnt <= '0;
      tcnt      <= '0;
      result_q  <= '0;
      cmd       <= '0;
      cmd_data  <= '0;
      cmd_exec  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= '0;
      err_code  <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      retry_cnt <= retry_nxt;
      tcnt      <= tcnt_nxt;
      result_q  <= result_nxt;
      cmd       <= cmd_nxt;
      cmd_data  <= cmd_data_nxt;
      cmd_exec  <= cmd_exec_nxt;
      done      <= done_nxt;
      error     <= error_nxt;
      err_index <= err_index_nxt;
      err_code  <= err_code_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_init_sequencer.sv
// Bench for ps2_init_sequencer. A controller/keyboard stand-in replays a script
// of per-attempt responses, and a table-walking model predicts the handshakes
// and the final flags from that same script.
module tb_ps2_init_sequencer;

  localparam int         T_CYC   = 50;
  localparam int         MAXR    = 2;
  localparam int         NCMD    = 4;
  localparam logic [8:0] HANG    = 9'h100;  // controller never raises busy
  localparam logic [8:0] ABORT   = 9'h101;  // pulse start while in WAIT_CMPL
  localparam logic [8:0] RESET_R = 9'h102;  // pulse rst while in WAIT_CMPL

  logic       clk = 1'b0;
  logic       rst, start, busy, cmd_complete;
  logic [7:0] cmd_result;
  logic [7:0] cmd, cmd_data;
  logic       cmd_exec, done, error, active;
  logic [3:0] err_index;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  ps2_init_sequencer #(.TIMEOUT_CYCLES(T_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .cmd_complete(cmd_complete), .cmd_result(cmd_result),
    .cmd(cmd), .cmd_data(cmd_data), .cmd_exec(cmd_exec),
    .done(done), .error(error), .err_index(err_index),
    .err_code(err_code), .active(active)
  );

  logic [15:0] tbl    [4] = '{16'hFF00, 16'hF320, 16'hED00, 16'hF400};
  logic [15:0] s1_lit [4] = '{16'hFF00, 16'hF320, 16'hED00, 16'hF400};

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [8:0]  scr_q[$];
  logic [15:0] run_exp[$];
  logic [15:0] obs_run[$];
  int          hs = 0;
  int          run_base = 0;
  bit          live = 1'b0;
  bit          prev_exec = 1'b0;
  logic        m_done, m_err;
  logic [1:0]  m_code;
  logic [3:0]  m_idx;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] obs_word(input int i);
    if (i < obs_run.size()) return obs_run[i];
    return 16'hxxxx;
  endfunction

  // Walk the table using the response script: one script entry per attempt.
  task automatic run_model();
    int ix, rt;
    logic [8:0] r;
    ix = 0;
    rt = 0;
    run_exp.delete();
    m_done = 1'b0; m_err = 1'b0; m_code = 2'd0; m_idx = 4'd0;
    for (int p = 0; p < scr_q.size(); p++) begin
      r = scr_q[p];
      run_exp.push_back(tbl[ix]);
      if (r == ABORT || r == RESET_R) begin
        ix = 0;
        rt = 0;
      end else if (r == 9'h0FA || (r == 9'h0AA && tbl[ix][15:8] == 8'hFF)) begin
        ix++;
        rt = 0;
        if (ix == NCMD) begin m_done = 1'b1; return; end
      end else if (r == 9'h0FE || r == HANG) begin
        if (rt < MAXR) rt++;
        else begin
          m_err = 1'b1; m_code = (r == HANG) ? 2'd1 : 2'd2; m_idx = 4'(ix);
          return;
        end
      end else begin
        m_err = 1'b1; m_code = 2'd3; m_idx = 4'(ix);
        return;
      end
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd"},       {24'h0, cmd},       32'h0);
    check({tag, "_cmd_data"},  {24'h0, cmd_data},  32'h0);
    check({tag, "_cmd_exec"},  {31'h0, cmd_exec},  32'h0);
    check({tag, "_done"},      {31'h0, done},      32'h0);
    check({tag, "_error"},     {31'h0, error},     32'h0);
    check({tag, "_err_index"}, {28'h0, err_index}, 32'h0);
    check({tag, "_err_code"},  {30'h0, err_code},  32'h0);
    check({tag, "_active"},    {31'h0, active},    32'h0);
  endtask

  // Per-cycle compare: the presented command must match the model's entry for
  // the current handshake, and no terminal flag may show before the last one.
  always @(negedge clk) begin : chk
    int ci;
    if (cmd_exec === 1'b1 && !prev_exec) begin
      obs_run.push_back({cmd, cmd_data});
      hs++;
    end
    prev_exec = (cmd_exec === 1'b1);
    if (live) begin
      ci = hs - run_base;
      if (cmd_exec === 1'b1) begin
        if (ci >= 1 && ci <= run_exp.size())
          check("cmd_word", {16'h0, cmd, cmd_data}, {16'h0, run_exp[ci-1]});
        else
          check("extra_handshake", ci, run_exp.size());
      end
      if (ci < run_exp.size())
        check("early_flag", {30'h0, done, error}, 32'h0);
    end
  end

  task automatic handshake(input logic [8:0] r);
    int n;
    n = 0;
    while (cmd_exec !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (cmd_exec !== 1'b1) begin
      check("cmd_exec_wait", n, 32'hFFFF_FFFF);
      return;
    end
    if (r == HANG) begin
      n = 0;
      while (cmd_exec === 1'b1 && n < 200) begin @(negedge clk); n++; end
      check("timeout_len", n, T_CYC);
      return;
    end
    repeat ($urandom_range(0, 4)) @(negedge clk);
    busy = 1'b1;
    n = 0;
    while (cmd_exec === 1'b1 && n < 60) begin @(negedge clk); n++; end
    if (cmd_exec === 1'b1) check("exec_drop", 1, 0);
    busy = 1'b0;
    repeat ($urandom_range(0, 5)) @(negedge clk);
    if (r == ABORT) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("abort_exec",  {31'h0, cmd_exec}, 32'h0);
      check("abort_flags", {28'h0, done, error, err_code}, 32'h0);
    end else if (r == RESET_R) begin
      rst = 1'b1;
      @(negedge clk);
      check_reset("mid_rst");
      rst = 1'b0;
    end else begin
      cmd_result   = r[7:0];
      cmd_complete = 1'b1;
      @(negedge clk);
      cmd_complete = 1'b0;
    end
  endtask

  task automatic do_run(input bit via_reset);
    int n;
    run_model();
    run_base = hs;
    obs_run.delete();
    if (via_reset) begin
      rst = 1'b0;
    end else begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    live = 1'b1;
    for (int k = 0; k < run_exp.size(); k++) handshake(scr_q[k]);
    n = 0;
    while (!(done === 1'b1 || error === 1'b1) && n < 300) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    live = 1'b0;
    check("run_len",   hs - run_base, run_exp.size());
    check("done",      {31'h0, done},      {31'h0, m_done});
    check("error",     {31'h0, error},     {31'h0, m_err});
    check("err_code",  {30'h0, err_code},  {30'h0, m_code});
    check("err_index", {28'h0, err_index}, {28'h0, m_idx});
    check("end_active", {31'h0, active},   32'h0);
    check("end_exec",  {31'h0, cmd_exec},  32'h0);
  endtask

  task automatic gen_random();
    int u;
    scr_q.delete();
    for (int i = 0; i < 40; i++) begin
      u = $urandom_range(0, 99);
      if (u < 55)      scr_q.push_back(9'h0FA);
      else if (u < 65) scr_q.push_back(9'h0AA);
      else if (u < 82) scr_q.push_back(9'h0FE);
      else if (u < 87) scr_q.push_back(HANG);
      else             scr_q.push_back({1'b0, 8'($urandom_range(0, 255))});
    end
  endtask

  initial begin : main
    int f3;
    rst = 1'b1; start = 1'b0; busy = 1'b0; cmd_complete = 1'b0; cmd_result = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("por");

    // All entries ACKed, started by reset release.
    scr_q.delete();
    scr_q.push_back(9'h0AA); scr_q.push_back(9'h0FA);
    scr_q.push_back(9'h0FA); scr_q.push_back(9'h0FA);
    do_run(1'b1);
    for (int i = 0; i < 4; i++) check("s1_cmd_seq", {16'h0, obs_word(i)}, {16'h0, s1_lit[i]});
    check("s1_done", {31'h0, done}, 32'h1);

    // Entry 1 resent twice, then ACKed.
    scr_q.delete();
    scr_q.push_back(9'h0AA); scr_q.push_back(9'h0FE); scr_q.push_back(9'h0FE);
    scr_q.push_back(9'h0FA); scr_q.push_back(9'h0FA); scr_q.push_back(9'h0FA);
    do_run(1'b0);
    f3 = 0;
    foreach (obs_run[i]) if (obs_run[i][15:8] == 8'hF3) f3++;
    check("s2_f3_count", f3, 3);
    check("s2_done", {31'h0, done}, 32'h1);

    // Entry 2 resent three times: retries exhausted.
    scr_q.delete();
    scr_q.push_back(9'h0AA); scr_q.push_back(9'h0FA);
    scr_q.push_back(9'h0FE); scr_q.push_back(9'h0FE); scr_q.push_back(9'h0FE);
    do_run(1'b0);
    check("s3_err", {28'h0, error, active, err_code}, {28'h0, 1'b1, 1'b0, 2'd2});
    check("s3_idx", {28'h0, err_index}, 32'd2);

    // Controller never takes the command: three 50-cycle attempts then timeout.
    scr_q.delete();
    scr_q.push_back(HANG); scr_q.push_back(HANG); scr_q.push_back(HANG);
    do_run(1'b0);
    check("s4_err", {29'h0, error, err_code}, {29'h0, 1'b1, 2'd1});
    check("s4_idx", {28'h0, err_index}, 32'd0);

    // Unexpected byte on entry 3: no retry.
    scr_q.delete();
    scr_q.push_back(9'h0AA); scr_q.push_back(9'h0FA);
    scr_q.push_back(9'h0FA); scr_q.push_back(9'h055);
    do_run(1'b0);
    check("s5_err", {29'h0, error, err_code}, {29'h0, 1'b1, 2'd3});
    check("s5_idx", {28'h0, err_index}, 32'd3);
    check("s5_attempts", obs_run.size(), 4);

    // start during WAIT_CMPL of entry 1: restart at FF.
    scr_q.delete();
    scr_q.push_back(9'h0AA); scr_q.push_back(ABORT);
    scr_q.push_back(9'h0AA); scr_q.push_back(9'h0FA);
    scr_q.push_back(9'h0FA); scr_q.push_back(9'h0FA);
    do_run(1'b0);
    check("s6_restart_cmd", {16'h0, obs_word(2)}, 32'h0000_FF00);
    check("s6_done", {31'h0, done}, 32'h1);

    // rst during WAIT_CMPL of entry 2: auto-restart from entry 0.
    scr_q.delete();
    scr_q.push_back(9'h0AA); scr_q.push_back(9'h0FA); scr_q.push_back(RESET_R);
    scr_q.push_back(9'h0AA); scr_q.push_back(9'h0FA);
    scr_q.push_back(9'h0FA); scr_q.push_back(9'h0FA);
    do_run(1'b0);
    check("s7_done", {31'h0, done}, 32'h1);

    for (int r = 0; r < 25; r++) begin
      gen_random();
      do_run(1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #(800_000);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
